// File: rtl/store_unit.sv
// Store formatter + small issue queue between EXE and the data bus bridge.
// Define STORE_ALIGN_CHECK_EN to add ades_ex and drop misaligned SH/SW.
module store_unit #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [31:0]             in_addr,
    input  logic [31:0]             in_data,
    input  logic                    flush,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [31:0]             data_addr,
    output logic [3:0]              data_wstrb,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    output logic                    busy,
`ifdef STORE_ALIGN_CHECK_EN
    output logic                    ades_ex,
`endif
    output logic [$clog2(DEPTH):0]  st_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;
    localparam logic [2:0] OP_SWL = 3'b011;
    localparam logic [2:0] OP_SWR = 3'b100;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_e;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } entry_t;

    state_e          state_q, state_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    entry_t          head;

    logic [1:0]      n;
    logic [3:0]      fmt_strb;
    logic [31:0]     fmt_data;
    logic            misalign;
    logic            push, pop, hs, inflight;

    assign n = in_addr[1:0];

    always_comb begin
        fmt_strb = 4'b0000;
        fmt_data = in_data;
        case (in_op)
            OP_SB: begin
                fmt_strb = 4'b0001 << n;
                fmt_data = {4{in_data[7:0]}};
            end
            OP_SH: begin
                fmt_strb = n[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{in_data[15:0]}};
            end
            OP_SW: fmt_strb = 4'b1111;
            // SWL fills the low bytes up to n with the top bytes of rt
            OP_SWL: begin
                case (n)
                    2'b00:   begin fmt_strb = 4'b0001; fmt_data = {24'b0, in_data[31:24]}; end
                    2'b01:   begin fmt_strb = 4'b0011; fmt_data = {16'b0, in_data[31:16]}; end
                    2'b10:   begin fmt_strb = 4'b0111; fmt_data = {8'b0, in_data[31:8]};   end
                    default: begin fmt_strb = 4'b1111; fmt_data = in_data;                 end
                endcase
            end
            OP_SWR: begin
                case (n)
                    2'b00:   begin fmt_strb = 4'b1111; fmt_data = in_data;                 end
                    2'b01:   begin fmt_strb = 4'b1110; fmt_data = {in_data[23:0], 8'b0};   end
                    2'b10:   begin fmt_strb = 4'b1100; fmt_data = {in_data[15:0], 16'b0};  end
                    default: begin fmt_strb = 4'b1000; fmt_data = {in_data[7:0], 24'b0};   end
                endcase
            end
            default: fmt_strb = 4'b0000;
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign misalign = ((in_op == OP_SH) && n[0]) || ((in_op == OP_SW) && (n != 2'b00));
    assign ades_ex  = in_valid && misalign && !reset;
`else
    assign misalign = 1'b0;
`endif

    assign in_ready = (count_q < CW'(DEPTH));

    always_comb begin
        inflight = (state_q != IDLE);
        push     = in_valid && in_ready && !flush && !misalign;
        hs       = (state_q == REQ) && data_addr_ok;
        pop      = (hs && data_data_ok) || ((state_q == WAIT_DATA) && data_data_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        // Flush keeps only the bus-owned head entry (REQ or WAIT_DATA)
        if (flush) begin
            wr_ptr_d = rd_ptr_q + PW'(inflight);
            count_d  = CW'(inflight && !pop);
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
        state_d = state_q;
        case (state_q)
            IDLE:      if (count_q != '0 && !flush) state_d = REQ;
            REQ:       if (hs) state_d = data_data_ok ? ((count_d != '0) ? REQ : IDLE) : WAIT_DATA;
            WAIT_DATA: if (data_data_ok) state_d = (count_d != '0) ? REQ : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: in_addr[31:2], wstrb: fmt_strb, wdata: fmt_data};
    end

    assign head       = mem_q[rd_ptr_q];
    assign data_req   = (state_q == REQ);
    assign data_wr    = data_req;
    assign data_size  = 2'b10;
    assign data_addr  = data_req ? {head.addr, 2'b00} : 32'h0;
    assign data_wstrb = data_req ? head.wstrb : 4'h0;
    assign data_wdata = data_req ? head.wdata : 32'h0;
    assign busy       = (count_q != '0);
    assign st_count   = count_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: a queue-level model predicts bus traffic,
// queue occupancy and request timing; a negedge monitor compares every cycle.
module tb_store_unit;
    localparam int DEPTH = 2;
    localparam int B_RAND = 0, B_ONE = 1, B_ZERO = 2, B_MAN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic        flush = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        busy;
    logic [$clog2(DEPTH):0] st_count;
`ifdef STORE_ALIGN_CHECK_EN
    logic        ades_ex;
`endif

    int   bus_mode = B_ZERO;
    logic rnd_aok = 1'b0, rnd_dok = 1'b0, man_aok = 1'b0, man_dok = 1'b0;

    always #5 clk = ~clk;

    assign data_addr_ok = (bus_mode == B_ONE) ? 1'b1 : (bus_mode == B_RAND) ? rnd_aok :
                          (bus_mode == B_MAN) ? man_aok : 1'b0;
    assign data_data_ok = (bus_mode == B_ONE) ? 1'b1 : (bus_mode == B_RAND) ? rnd_dok :
                          (bus_mode == B_MAN) ? man_dok : 1'b0;

    always @(posedge clk) begin
        #1;
        rnd_aok = ($urandom_range(0, 2) != 0);
        rnd_dok = ($urandom_range(0, 2) == 0);
    end

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_data(in_data), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .busy(busy),
`ifdef STORE_ALIGN_CHECK_EN
        .ades_ex(ades_ex),
`endif
        .st_count(st_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          chk_data;
    } exp_t;

    exp_t q[$];
    bit   m_active = 1'b0, m_acc = 1'b0;
    int   nvec = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Byte-lane view: SWL writes bytes 0..n from rt's top, SWR writes bytes n..3 from rt's bottom
    function automatic exp_t model_fmt(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rt);
        exp_t e;
        int   k = int'(a[1:0]);
        e.addr = {a[31:2], 2'b00};
        e.chk_data = 1'b1;
        case (op)
            3'd0: begin e.strb = 4'(1 << k);             e.wdata = {4{rt[7:0]}};   end
            3'd1: begin e.strb = 4'(3 << (k & 2));       e.wdata = {2{rt[15:0]}};  end
            3'd2: begin e.strb = 4'hF;                   e.wdata = rt;             end
            3'd3: begin e.strb = 4'((1 << (k + 1)) - 1); e.wdata = rt >> (8 * (3 - k)); end
            3'd4: begin e.strb = 4'(15 << k);            e.wdata = rt << (8 * k);  end
            default: begin e.strb = 4'h0; e.wdata = rt; e.chk_data = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic bit model_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
        return (op == 3'd1 && a[0]) || (op == 3'd2 && a[1:0] != 2'b00);
`else
        return (op == 3'd7) && (a == 32'h1) && 1'b0;
`endif
    endfunction

    always @(negedge clk) begin : monitor
        bit   push, hs, pop, mis;
        int   sz;
        exp_t e;
        if (reset) begin
            q.delete();
            m_active = 1'b0;
            m_acc    = 1'b0;
        end else begin
            sz  = q.size();
            mis = model_mis(in_op, in_addr);
            chk("in_ready", 32'(in_ready), 32'(sz < DEPTH));
            chk("st_count", 32'(st_count), 32'(sz));
            chk("busy", 32'(busy), 32'(sz != 0));
            chk("data_req", 32'(data_req), 32'(m_active && !m_acc));
`ifdef STORE_ALIGN_CHECK_EN
            chk("ades_ex", 32'(ades_ex), 32'(in_valid && mis));
`endif
            if (data_req && sz > 0) begin
                chk("data_addr", data_addr, q[0].addr);
                chk("data_wstrb", 32'(data_wstrb), 32'(q[0].strb));
                if (q[0].chk_data) chk("data_wdata", data_wdata, q[0].wdata);
                chk("data_wr", 32'(data_wr), 32'h1);
                chk("data_size", 32'(data_size), 32'h2);
            end
            // advance the model across the coming edge
            e    = model_fmt(in_op, in_addr, in_data);
            push = in_valid && (sz < DEPTH) && !flush && !mis;
            hs   = m_active && !m_acc && data_addr_ok;
            pop  = (m_acc && data_data_ok) || (hs && data_data_ok);
            if (pop) void'(q.pop_front());
            if (flush) begin
                if (m_active && !pop) begin
                    while (q.size() > 1) void'(q.pop_back());
                end else q.delete();
            end
            if (push) q.push_back(e);
            if (pop) m_acc = 1'b0;
            else if (hs) m_acc = 1'b1;
            if (!m_active) m_active = (sz > 0) && !flush;
            else if (pop) m_active = (q.size() > 0);
        end
    end

    task automatic cyc(input int k = 1);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic push_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        in_valid = 1'b1; in_op = op; in_addr = a; in_data = d;
        while (!in_ready && t < 100) begin cyc(); t++; end
        if (t >= 100) begin
            nvec++; nerr++;
            $display("FAIL push_timeout @%0t: in_ready stuck at 0, expected 1", $time);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || m_active || busy) && t < 300) begin cyc(); t++; end
        nvec++;
        if (t >= 300) begin
            nerr++;
            $display("FAIL drain_timeout @%0t: busy=%0b, expected 0", $time, busy);
        end
    endtask

    task automatic wait_req();
        int t = 0;
        while (!data_req && t < 50) begin cyc(); t++; end
        nvec++;
        if (t >= 50) begin
            nerr++;
            $display("FAIL req_timeout @%0t: data_req=0, expected 1", $time);
        end
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc();
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wstrb", 32'(data_wstrb), 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);

        // single stores through a random-latency bus
        bus_mode = B_RAND;
        push_op(3'd0, 32'h0000_1003, 32'h0000_00AB);
        wait_idle();
        push_op(3'd3, 32'h0000_2001, 32'h1122_3344);
        push_op(3'd4, 32'h0000_2001, 32'h1122_3344);
        wait_idle();

        // stall on a full queue with the bus refusing addresses
        bus_mode = B_MAN; man_aok = 1'b0; man_dok = 1'b0;
        push_op(3'd2, 32'h0000_4000, 32'hAAAA_0001);
        push_op(3'd2, 32'h0000_4004, 32'hAAAA_0002);
        in_valid = 1'b1; in_op = 3'd2; in_addr = 32'h0000_4008; in_data = 32'hAAAA_0003;
        cyc(3);
        chk("full_ready", 32'(in_ready), 32'h0);
        chk("full_count", 32'(st_count), 32'h2);
        chk("full_head", data_addr, 32'h0000_4000);
        man_aok = 1'b1; cyc(); man_aok = 1'b0;
        cyc(2);
        man_dok = 1'b1; cyc(); man_dok = 1'b0;
        cyc();
        in_valid = 1'b0;
        bus_mode = B_RAND;
        wait_idle();

        // zero-wait bus
        bus_mode = B_ONE;
        for (int i = 0; i < 4; i++) push_op(3'd1, 32'h0000_5000 + 32'(i * 2), 32'h0000_BE00 + 32'(i));
        wait_idle();
        chk("zw_count", 32'(st_count), 32'h0);
        chk("zw_busy", 32'(busy), 32'h0);

        // flush with the head waiting for data_ok
        bus_mode = B_MAN; man_aok = 1'b0; man_dok = 1'b0;
        push_op(3'd2, 32'h0000_6000, 32'h1111_1111);
        push_op(3'd2, 32'h0000_6004, 32'h2222_2222);
        wait_req();
        man_aok = 1'b1; cyc(); man_aok = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;
        cyc(2);
        man_dok = 1'b1; cyc(); man_dok = 1'b0;
        cyc(5);
        chk("flush_count", 32'(st_count), 32'h0);
        chk("flush_req", 32'(data_req), 32'h0);

        // reset in REQ, then a stale data_ok
        man_aok = 1'b0;
        push_op(3'd0, 32'h0000_7001, 32'h0000_0055);
        wait_req();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_req", 32'(data_req), 32'h0);
        chk("rst_count", 32'(st_count), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        man_dok = 1'b1; cyc(); man_dok = 1'b0;
        cyc(3);

`ifdef STORE_ALIGN_CHECK_EN
        in_valid = 1'b1; in_op = 3'd2; in_addr = 32'h0000_3002; in_data = 32'hDEAD_BEEF;
        chk("ades_sw", 32'(ades_ex), 32'h1);
        cyc(); in_valid = 1'b0;
        cyc(4);
        chk("ades_noreq", 32'(data_req), 32'h0);
`endif

        // random traffic including reserved ops and flushes
        bus_mode = B_RAND;
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_op    = 3'($urandom_range(0, 7));
            in_addr  = $urandom;
            in_data  = $urandom;
            flush    = ($urandom_range(0, 31) == 0);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
